freq_meter: RTL

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 15 +
 rtl/sig_sync_edge.sv | 35 +++
 rtl/freq_meter.sv | 117 +++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types and default constants for the frequency meter
// Purpose: measurement FSM state encoding and the default sysclk rate / counter width.
// Ports: none (package).
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam int SYSCLK_HZ = 100000000;
  localparam int DEF_CNT_W = 24;

endpackage

// File: rtl/sig_sync_edge.sv
// rtl/sig_sync_edge.sv - two-flop synchronizer with rising-edge detect
// Purpose: bring an asynchronous input into the sysclk domain and flag its rising edges.
// Ports:
//   sysclk  - system clock
//   reset_n - asynchronous active-low reset; clears all history
//   din     - asynchronous input
//   rise    - high for one cycle per synchronized 0->1 transition
module sig_sync_edge (
  input  logic sysclk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // History clears to 0, so a signal already high at reset release shows up
  // only once it has passed through both synchronizer stages.
  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated edge-counting frequency meter
// Purpose: count rising edges of sigin over a gate of GATE_CYCLES sysclk cycles and
//          publish the count (Hz for a 1 s gate) with a saturation flag.
// Ports:
//   sysclk     - system clock, the only clock
//   reset_n    - asynchronous active-low reset
//   sigin      - signal under test, asynchronous to sysclk
//   start      - one-cycle request to begin a measurement (honoured in IDLE only)
//   continuous - when high, a new gate begins after every result
//   busy       - high while the gate is open
//   done       - one-cycle pulse when freq/ovf are updated
//   freq       - edges counted in the last gate
//   ovf        - the last gate saturated the edge counter
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = SYSCLK_HZ,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             sysclk,
  input  logic             reset_n,
  input  logic             sigin,
  input  logic             start,
  input  logic             continuous,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq,
  output logic             ovf
);

  localparam int               GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;
  logic             rise;

  sig_sync_edge u_sync (
    .sysclk  (sysclk),
    .reset_n (reset_n),
    .din     (sigin),
    .rise    (rise)
  );

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    case (state_q)
      IDLE: begin
        if (start || continuous) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end
      end
      GATE: begin
        if (rise) begin
          if (edge_cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
        end
        // Results are captured from the next-state values so an edge on the
        // final gate cycle is included, and they are already stable while
        // done is high in LATCH.
        if (gate_cnt_q == GATE_LAST) begin
          state_d = LATCH;
          freq_d  = edge_cnt_d;
          ovf_d   = sat_d;
        end else begin
          gate_cnt_d = gate_cnt_q + GW'(1);
        end
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy = (state_q == GATE);
  assign done = (state_q == LATCH);
  assign freq = freq_q;
  assign ovf  = ovf_q;

endmodule
